uart_mmio: RTL
==============

// Module: uart_mmio
// PURPOSE
//  Memory-mapped 8N1 UART on the CPU data bus; consumes read/address/dout, drives read data and a select flag to the din mux.
//  Clocked on the CPU's falling clk edge, so side effects coincide with the CPU's data sample.
//  TX FIFO buffers bytes stored by STRL; single-byte RX holding register is read by LDRL.
// PARAMETERS
//  BASE_ADDR  16'hFF00  block base; decoded window is BASE_ADDR[15:3], 8 bytes
//  TX_DEPTH   4         TX FIFO entries, power of two, >=2
//  DIV_RESET  16'd104   reset bit period in clk cycles (>=4)
// PORTS
//  clk      in   1   system clock; all state updates on negedge clk
//  rst      in   1   synchronous, active-high reset, sampled on negedge clk
//  read     in   1   CPU read request; 0 = write cycle
//  address  in   16  CPU address
//  wdata    in   8   CPU write data (CPU dout)
//  rdata    out  8   read data to CPU din mux; 8'h00 when sel=0
//  sel      out  1   combinational: address[15:3]==BASE_ADDR[15:3]
//  uart_tx  out  1   serial out, idle high
//  uart_rx  in   1   serial in, asynchronous
// BEHAVIOUR
//  Register map (address[2:0]): 0 DATA, 1 STATUS, 2 DIVL, 3 DIVH, 4 CTRL, 5-7 read 0, writes ignored.
//  rdata is combinational from address; write strobe = sel & ~read, acted on at the negedge it is seen (one per cycle).
//  DATA write: push wdata into TX FIFO; dropped silently when full (no pointer change).
//  DATA read: returns RX holding byte; if sel & read & offset 0 & rx_valid at a negedge, clear rx_valid (pop).
//  STATUS read: {3'b0, tx_busy, rx_overrun, rx_valid, tx_empty, tx_full}; STATUS write (any data) clears rx_overrun.
//  DIVL/DIVH: 16-bit divisor, byte-writable; value <4 is treated as 4; change takes effect at next start bit.
//  Reset: uart_tx=1, FIFO empty (tx_empty=1, tx_full=0), rx_valid=0, rx_overrun=0, tx_busy=0, divisor=DIV_RESET, CTRL=0.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each state lasts divisor clocks.
//   IDLE pops FIFO head when non-empty and enters START on the same edge; tx_busy=1 outside IDLE.
//   Back-to-back bytes: STOP -> START directly if FIFO non-empty (no idle bit).
//   Push and pop in the same cycle on a full FIFO: pop wins, push accepted; count unchanged.
//  RX: uart_rx through 2-flop synchroniser. FSM: IDLE -> START -> DATA -> STOP.
//   IDLE: falling edge seen -> START; START samples at divisor/2, returns to IDLE if high (glitch reject).
//   DATA: 8 samples at divisor spacing, LSB first. STOP: sample at divisor; if high, store byte.
//   Store while rx_valid=1: keep old byte, set rx_overrun. Stop bit low: discard byte (framing), no flag.
//   Store and DATA-read pop in same cycle: new byte stored, rx_valid stays 1, no overrun.
//  FIFO pointers are log2(TX_DEPTH)+1 bits; wrap modulo 2*TX_DEPTH; full when MSBs differ and rest equal.
//  rst mid-frame: uart_tx goes high the next edge; partially received byte discarded.
// CONFIGURATION
//  UART_LOOPBACK_EN defined: CTRL bit0 = loopback; when 1, RX input is internal TX line (after synchroniser),
//   uart_tx held high; CTRL reads {7'b0, loopback}.
//  UART_LOOPBACK_EN undefined: CTRL reads 8'h00, writes ignored, no loopback logic synthesised.
// TESTING
//  Reset, divisor=8: STATUS reads 8'h02, uart_tx=1, sel=1 only for addresses FF00-FF07 (sel=0 at FEFF, FF08).
//  Write DATA 8'hA5 -> uart_tx: 8 clk low, bits 1,0,1,0,0,1,0,1 (8 clk each), 8 clk high; tx_busy during frame.
//  Write 5 bytes 01..05 with TX_DEPTH=4 while idle -> first pops at once, 4 buffered, all 5 sent back-to-back;
//   6th write while full dropped (tx_full=1).
//  Drive uart_rx frame 8'h3C at divisor 8 -> rx_valid=1, DATA reads 3C, next STATUS shows rx_valid=0.
//  Two frames 11, 22 without reading -> DATA=11, rx_overrun=1; STATUS write clears it; framing-error frame ignored.
//  UART_LOOPBACK_EN: CTRL=1, write 8'h5A -> rx_valid=1, DATA=5A, uart_tx stays 1; without macro CTRL reads 00.

Source files
------------

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio
// Purpose  : Memory-mapped 8N1 UART (TX FIFO, RX holding register), negedge clocked.
// Options  : define UART_LOOPBACK_EN to enable the CTRL loopback bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int unsigned TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        sel,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int unsigned c_aw = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    logic [2:0]  w_offset;
    logic        w_wr;
    logic        w_rd;
    logic [15:0] w_eff_div;
    logic [7:0]  w_status;
    logic [7:0]  w_ctrl;
    logic        w_rx_src;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic [7:0]  w_fifo_head;
    logic        w_push;
    logic        w_tx_pop;
    logic        w_rx_store;
    logic        w_rx_pop;

    logic [15:0] div_q, div_d;
    logic [7:0]  fifo_mem_q [TX_DEPTH];
    logic [7:0]  fifo_mem_d [TX_DEPTH];
    logic [c_aw:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;

    // Bus decode
    assign w_offset  = address[2:0];
    assign sel       = (address[15:3] == BASE_ADDR[15:3]);
    assign w_wr      = sel & ~read;
    assign w_rd      = sel & read;
    assign w_eff_div = (div_q < 16'd4) ? 16'd4 : div_q;
    assign w_status  = {3'b000, (tx_state_q != TX_IDLE), rx_overrun_q, rx_valid_q,
                        w_fifo_empty, w_fifo_full};

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (w_offset)
                3'd0:    rdata = rx_data_q;
                3'd1:    rdata = w_status;
                3'd2:    rdata = div_q[7:0];
                3'd3:    rdata = div_q[15:8];
                3'd4:    rdata = w_ctrl;
                default: rdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        div_d = div_q;
        if (w_wr && w_offset == 3'd2) div_d[7:0]  = wdata;
        if (w_wr && w_offset == 3'd3) div_d[15:8] = wdata;
    end

    // TX FIFO; a push on a full FIFO is still accepted when the head leaves this cycle
    assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign w_fifo_full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                          (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign w_fifo_head  = fifo_mem_q[rd_ptr_q[c_aw-1:0]];
    assign w_push       = w_wr && (w_offset == 3'd0) && (!w_fifo_full || w_tx_pop);

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (w_push) begin
            fifo_mem_d[wr_ptr_q[c_aw-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + {{c_aw{1'b0}}, 1'b1};
        end
        if (w_tx_pop) rd_ptr_d = rd_ptr_q + {{c_aw{1'b0}}, 1'b1};
    end

    // TX FSM; divisor is latched per frame so register writes mid-frame do not distort it
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = 16'd0;
                if (!w_fifo_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_shift_d = w_fifo_head;
                    tx_div_d   = w_eff_div;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_cnt_d   = 16'd0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_cnt_d = 16'd0;
                    if (!w_fifo_empty) begin
                        w_tx_pop   = 1'b1;
                        tx_shift_d = w_fifo_head;
                        tx_div_d   = w_eff_div;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    // RX FSM on the synchronised line
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        w_rx_store = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (!rx_sync_q && rx_prev_q) begin
                    rx_div_d   = w_eff_div;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    w_rx_store = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Holding register: a pop in the same cycle as a store makes room for the new byte
    assign w_rx_pop = w_rd && (w_offset == 3'd0) && rx_valid_q;

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        if (w_wr && w_offset == 3'd1) rx_overrun_d = 1'b0;
        if (w_rx_store) begin
            if (rx_valid_q && !w_rx_pop) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end else if (w_rx_pop) begin
            rx_valid_d = 1'b0;
        end
    end

`ifdef UART_LOOPBACK_EN
    logic loopback_q, loopback_d;

    always_comb begin
        loopback_d = loopback_q;
        if (w_wr && w_offset == 3'd4) loopback_d = wdata[0];
    end

    always_ff @(negedge clk) begin
        if (rst) loopback_q <= 1'b0;
        else     loopback_q <= loopback_d;
    end

    assign w_rx_src = loopback_q ? tx_line_q : uart_rx;
    assign uart_tx  = loopback_q | tx_line_q;
    assign w_ctrl   = {7'b0000000, loopback_q};
`else
    assign w_rx_src = uart_rx;
    assign uart_tx  = tx_line_q;
    assign w_ctrl   = 8'h00;
`endif

    always_ff @(negedge clk) begin
        if (rst) begin
            div_q        <= DIV_RESET;
            fifo_mem_q   <= '{default: 8'h00};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= 16'd0;
            tx_div_q     <= 16'd4;
            tx_bit_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            tx_line_q    <= 1'b1;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= 16'd0;
            rx_div_q     <= 16'd4;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_div_q     <= tx_div_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_line_q    <= tx_line_d;
            rx_meta_q    <= w_rx_src;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_div_q     <= rx_div_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

endmodule
`default_nettype wire
